// File: rtl/photo_pkg.sv
// photo_pkg: shared defaults and width helpers for the photo-interrupter front end.
//   DEF_DEB_CYCLES     - default debounce length (stable samples to accept a change)
//   DEF_CNT_W          - default event-counter width
//   DEF_STRETCH_CYCLES - default LED stretch after the debounced level falls
//   deb_cnt_w()        - width of the per-channel debounce counter
//   stretch_cnt_w()    - width of the per-channel stretch counter (never below 1)
package photo_pkg;

  localparam int DEF_DEB_CYCLES     = 1000;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_STRETCH_CYCLES = 0;

  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

  // A zero stretch still needs a 1-bit counter so the logic stays uniform.
  function automatic int stretch_cnt_w(input int stretch_cycles);
    return (stretch_cycles < 1) ? 1 : $clog2(stretch_cycles + 1);
  endfunction

endpackage

// File: rtl/photo_chan.sv
// photo_chan: one photo-interrupter channel.
//   clk, rst  - clock, asynchronous active-high reset
//   sensor    - raw asynchronous sensor line (high = beam interrupted)
//   clr_cnt   - clears the event counter (wins over a same-cycle event)
//   irq_ack   - clears the sticky interrupt flag
//   level     - debounced sensor state
//   led       - level plus stretch
//   irq       - sticky event flag
//   cnt       - saturating count of level rises
module photo_chan
  import photo_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor,
  input  logic             clr_cnt,
  input  logic             irq_ack,
  output logic             level,
  output logic             led,
  output logic             irq,
  output logic [CNT_W-1:0] cnt
);

  localparam int DEB_W = deb_cnt_w(DEB_CYCLES);
  localparam int ST_W  = stretch_cnt_w(STRETCH_CYCLES);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LOAD  = ST_W'(STRETCH_CYCLES);

  logic             sync_q1;
  logic             sync;
  logic [DEB_W-1:0] deb_cnt;
  logic             level_d;
  logic             evt;
  logic [ST_W-1:0]  stretch_cnt;

  // Two-flop synchroniser for the asynchronous sensor line.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= sensor;
      sync    <= sync_q1;
    end
  end

  // Debounce: count consecutive samples that disagree with level; the
  // DEB_CYCLES-th disagreeing sample flips level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (sync == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      level   <= ~level;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Rising-edge detect on the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign evt = level & ~level_d;

  // Saturating event counter; clear has priority over a coincident event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr_cnt)            cnt <= '0;
    else if (evt && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

  // Sticky flag: a set wins over a same-cycle ack so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq <= 1'b0;
    else if (evt)     irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end

  // Stretch counter is held at full load while level is high and drains
  // once it falls; a re-rise simply reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     stretch_cnt <= '0;
    else if (level)              stretch_cnt <= ST_LOAD;
    else if (stretch_cnt != '0)  stretch_cnt <= stretch_cnt - ST_W'(1);
  end

  assign led = level | (|stretch_cnt);

endmodule

// File: rtl/photo_sensor_array.sv
// photo_sensor_array: N_CH independent photo-interrupter channels.
//   clk, rst  - clock, asynchronous active-high reset
//   sensor    - raw sensor lines, one per channel
//   clr_cnt   - clears all event counters
//   irq_ack   - per-channel interrupt acknowledge
//   cnt_sel   - channel whose counter is shown on cnt_out
//   level     - debounced states
//   led       - stretched LED drives
//   irq       - sticky per-channel event flags
//   irq_any   - OR of irq
//   cnt_out   - registered count of channel cnt_sel (0 when out of range)
module photo_sensor_array
  import photo_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int SEL_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sensor,
  input  logic             clr_cnt,
  input  logic [N_CH-1:0]  irq_ack,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [N_CH-1:0]  level,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  irq,
  output logic             irq_any,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int N_SEL = 2 ** SEL_W;

  // One entry per selector code so the mux index never leaves the array.
  logic [CNT_W-1:0] cnt_arr [N_SEL];

  for (genvar i = 0; i < N_SEL; i++) begin : g_ch
    if (i < N_CH) begin : g_live
      logic [CNT_W-1:0] chan_cnt;

      photo_chan #(
        .CNT_W          (CNT_W),
        .DEB_CYCLES     (DEB_CYCLES),
        .STRETCH_CYCLES (STRETCH_CYCLES)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .sensor  (sensor[i]),
        .clr_cnt (clr_cnt),
        .irq_ack (irq_ack[i]),
        .level   (level[i]),
        .led     (led[i]),
        .irq     (irq[i]),
        .cnt     (chan_cnt)
      );

      assign cnt_arr[i] = chan_cnt;
    end else begin : g_pad
      // NOTE: unused selector codes are tied to zero explicitly, so the mux
      // below is fully specified for every cnt_sel value and nothing latches.
      assign cnt_arr[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_out <= '0;
    else     cnt_out <= cnt_arr[cnt_sel];
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_photo_sensor_array.sv
// tb_photo_sensor_array: directed stimulus with a cycle-level behavioural
// model of each channel, a per-cycle compare process and literal pins.
module tb_photo_sensor_array;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;
  localparam int STR   = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_CH-1:0]  sensor = '0;
  logic             clr_cnt = 1'b0;
  logic [N_CH-1:0]  irq_ack = '0;
  logic [1:0]       cnt_sel = '0;
  logic [N_CH-1:0]  level;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  irq;
  logic             irq_any;
  logic [CNT_W-1:0] cnt_out;

  photo_sensor_array #(
    .N_CH           (N_CH),
    .CNT_W          (CNT_W),
    .DEB_CYCLES     (DEB),
    .STRETCH_CYCLES (STR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sensor  (sensor),
    .clr_cnt (clr_cnt),
    .irq_ack (irq_ack),
    .cnt_sel (cnt_sel),
    .level   (level),
    .led     (led),
    .irq     (irq),
    .irq_any (irq_any),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit model_on = 1'b0;

  // Model state: two-stage sample delay, run length of samples that disagree
  // with the accepted level, accepted level and its previous value, event
  // count, flag, and edges elapsed since level was last seen high.
  int m_s1    [N_CH];
  int m_s2    [N_CH];
  int m_lvl   [N_CH];
  int m_lvl_d [N_CH];
  int m_run   [N_CH];
  int m_cnt   [N_CH];
  int m_irq   [N_CH];
  int m_off   [N_CH];
  int m_cnt_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvl_d[i] = 0;
      m_run[i] = 0; m_cnt[i] = 0; m_irq[i] = 0; m_off[i] = STR;
    end
    m_cnt_out = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    m_cnt_out = m_cnt[cnt_sel];
    for (int i = 0; i < N_CH; i++) begin
      bit evt;
      evt = (m_lvl[i] == 1) && (m_lvl_d[i] == 0);
      if (clr_cnt)                    m_cnt[i] = 0;
      else if (evt && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      if (evt)             m_irq[i] = 1;
      else if (irq_ack[i]) m_irq[i] = 0;
      m_off[i]   = (m_lvl[i] == 1) ? 0 : ((m_off[i] < STR) ? m_off[i] + 1 : STR);
      m_lvl_d[i] = m_lvl[i];
      if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
      else if (m_run[i] + 1 == DEB) begin
        m_lvl[i] = 1 - m_lvl[i];
        m_run[i] = 0;
      end else m_run[i] = m_run[i] + 1;
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(sensor[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [N_CH-1:0] e_lvl, e_led, e_irq;
    if (model_on) begin
      for (int i = 0; i < N_CH; i++) begin
        e_lvl[i] = (m_lvl[i] == 1);
        e_led[i] = (m_lvl[i] == 1) || (m_off[i] < STR);
        e_irq[i] = (m_irq[i] == 1);
      end
      check("level",   32'(level),   32'(e_lvl));
      check("led",     32'(led),     32'(e_led));
      check("irq",     32'(irq),     32'(e_irq));
      check("irq_any", 32'(irq_any), 32'(|e_irq));
      check("cnt_out", 32'(cnt_out), 32'(m_cnt_out));
    end
  end

  initial begin
    model_reset();
    step(2);
    model_on = 1'b1;
    rst = 1'b0;
    step(2);

    // All channels rise together: level at the 6th sampling edge, then one event each.
    sensor = 4'hF;
    step(6);
    check("lit_level_all_up", 32'(level), 32'h0000000F);
    step(1);
    check("lit_irq_all", 32'(irq), 32'h0000000F);
    for (int i = 0; i < N_CH; i++) begin
      cnt_sel = 2'(i);
      step(1);
      check($sformatf("lit_cnt_ch%0d", i), 32'(cnt_out), 32'd1);
    end

    // Mid-cycle asynchronous reset with the sensors still high.
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("lit_rst_level", 32'(level), 32'd0);
    check("lit_rst_led",   32'(led),   32'd0);
    check("lit_rst_irq",   32'({irq_any, irq}), 32'd0);
    check("lit_rst_cnt",   32'(cnt_out), 32'd0);
    step(2);
    rst = 1'b0;
    step(5);
    check("lit_level_pre", 32'(level), 32'd0);
    step(1);
    check("lit_level_post", 32'(level), 32'h0000000F);

    // Quiesce: drop sensors, let LEDs drain, ack and clear.
    sensor = '0;
    step(16);
    irq_ack = 4'hF;
    step(1);
    irq_ack = '0;
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    check("lit_quiet_irq", 32'({irq_any, irq}), 32'd0);

    // Glitch rejection on ch0.
    cnt_sel = 2'd0;
    sensor[0] = 1'b1;
    step(3);
    sensor[0] = 1'b0;
    step(10);
    check("lit_glitch_level", 32'(level[0]), 32'd0);
    check("lit_glitch_led",   32'(led[0]),   32'd0);
    check("lit_glitch_irq",   32'(irq[0]),   32'd0);
    check("lit_glitch_cnt",   32'(cnt_out),  32'd0);
    sensor[0] = 1'b1;
    step(6);
    check("lit_accept_level", 32'(level[0]), 32'd1);
    sensor[0] = 1'b0;
    step(12);
    check("lit_accept_irq", 32'(irq[0]),  32'd1);
    check("lit_accept_cnt", 32'(cnt_out), 32'd1);

    // Saturation on ch1, then a clear coinciding with the 21st event.
    cnt_sel = 2'd1;
    repeat (20) begin
      sensor[1] = 1'b1;
      step(6);
      sensor[1] = 1'b0;
      step(6);
    end
    check("lit_sat_cnt", 32'(cnt_out), 32'd15);
    sensor[1] = 1'b1;
    step(6);
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    step(1);
    check("lit_clr_cnt", 32'(cnt_out), 32'd0);
    check("lit_clr_irq", 32'(irq[1]),  32'd1);
    sensor[1] = 1'b0;
    step(6);

    // IRQ race on ch2.
    irq_ack = 4'hF;
    step(1);
    irq_ack = '0;
    sensor[2] = 1'b1;
    step(6);
    irq_ack[2] = 1'b1;
    step(1);
    irq_ack = '0;
    check("lit_race_irq", 32'(irq[2]), 32'd1);
    irq_ack[2] = 1'b1;
    step(1);
    irq_ack = '0;
    check("lit_ack_irq", 32'(irq[2]),  32'd0);
    check("lit_ack_any", 32'(irq_any), 32'd0);
    sensor[2] = 1'b0;
    step(6);

    // Stretch on ch3: level falls at edge T, LED low at T+8.
    sensor[3] = 1'b1;
    step(8);
    sensor[3] = 1'b0;
    step(6);
    check("lit_str_level", 32'(level[3]), 32'd0);
    check("lit_str_led_t", 32'(led[3]),   32'd1);
    step(7);
    check("lit_str_led_t7", 32'(led[3]), 32'd1);
    step(1);
    check("lit_str_led_t8", 32'(led[3]), 32'd0);

    // Re-rise at T+5 keeps the LED lit throughout.
    sensor[3] = 1'b1;
    step(8);
    sensor[3] = 1'b0;
    step(5);
    sensor[3] = 1'b1;
    step(1);
    check("lit_rr_level_t", 32'(level[3]), 32'd0);
    check("lit_rr_led_t",   32'(led[3]),   32'd1);
    step(4);
    check("lit_rr_led_t4",  32'({level[3], led[3]}), 32'b01);
    step(1);
    check("lit_rr_led_t5",  32'({level[3], led[3]}), 32'b11);
    sensor[3] = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
